// File: rtl/board_mem_arbiter_if.sv
// Board tile RAM bus: draw read port, game read/write port and the RAM command/return.
// slave = arbiter side; master = requesters plus RAM side.
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_rdata;
  logic              draw_rvalid;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic [DATA_W-1:0] game_rdata;
  logic              game_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  draw_req, draw_addr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    output draw_rdata, draw_rvalid, game_gnt, game_rdata, game_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output draw_req, draw_addr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    input  draw_rdata, draw_rvalid, game_gnt, game_rdata, game_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Frame-synchronous arbiter for the single-port board RAM: draw reads always win,
// game accesses only in the vblank of tick frames; also produces the game tick.
module board_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vblnk,
  board_mem_arbiter_if.slave  bus,
  output logic                game_tick,
  output logic                update_window
);
  typedef enum logic [1:0] {S_DRAW, S_UPDATE, S_LOCK} state_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  state_t            state, state_nxt;
  logic              vblnk_q, vb_rise, vb_fall, tick_frame, gnt;
  logic [7:0]        frame_cnt;
  cmd_t              cmd;
  logic [1:0]        tag_in;
  logic [2:1][1:0]   tag_pipe;

  assign vb_rise    = vblnk & ~vblnk_q;
  assign vb_fall    = ~vblnk & vblnk_q;
  assign tick_frame = (frame_cnt == TICK_LAST);

  // vblnk_q resets high so a vblank already in progress at release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q   <= 1'b1;
      frame_cnt <= '0;
      game_tick <= 1'b0;
    end else begin
      vblnk_q   <= vblnk;
      game_tick <= vb_rise & tick_frame;
      if (vb_rise) frame_cnt <= tick_frame ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_DRAW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DRAW:   if (vb_rise) state_nxt = tick_frame ? S_UPDATE : S_LOCK;
      S_UPDATE: if (vb_fall) state_nxt = S_DRAW;
      S_LOCK:   if (vb_fall) state_nxt = S_DRAW;
      default:  state_nxt = S_DRAW;
    endcase
  end

  always_comb begin
    update_window = (state == S_UPDATE);
    gnt           = bus.game_req & (state == S_UPDATE) & ~bus.draw_req;
  end

  // Command register; addr/wdata hold when idle to avoid needless RAM-pin toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (bus.draw_req) begin
      cmd.en   <= 1'b1;
      cmd.we   <= 1'b0;
      cmd.addr <= bus.draw_addr;
    end else if (gnt) begin
      cmd.en    <= 1'b1;
      cmd.we    <= bus.game_we;
      cmd.addr  <= bus.game_addr;
      cmd.wdata <= bus.game_wdata;
    end else begin
      cmd.en <= 1'b0;
      cmd.we <= 1'b0;
    end
  end

  // Owner tag {draw, game} follows each read through the RAM's one-cycle latency
  assign tag_in = {bus.draw_req, gnt & ~bus.game_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_pipe <= '0;
    else        tag_pipe <= {tag_pipe[1], tag_in};
  end

  assign bus.game_gnt    = gnt;
  assign bus.mem_en      = cmd.en;
  assign bus.mem_we      = cmd.we;
  assign bus.mem_addr    = cmd.addr;
  assign bus.mem_wdata   = cmd.wdata;
  assign bus.draw_rdata  = bus.mem_rdata;
  assign bus.game_rdata  = bus.mem_rdata;
  assign bus.draw_rvalid = tag_pipe[2][1];
  assign bus.game_rvalid = tag_pipe[2][0];
endmodule
